// File: rtl/interfpga_tx_arbiter_if.sv
// interfpga_tx_arbiter_if: requester handshake and link-sender signals of the tx arbiter
// master = arbiter side, slave = requesters plus interfpga_send side
interface interfpga_tx_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic [7:0]           tx_data;
    logic                 tx_send;
    logic                 tx_busy;
    modport master (input req_valid, req_data, tx_busy, output req_ack, tx_data, tx_send);
    modport slave (output req_valid, req_data, tx_busy, input req_ack, tx_data, tx_send);
endinterface

// File: rtl/interfpga_tx_arbiter.sv
// interfpga_tx_arbiter: round-robin share of one interfpga_send link among NUM_REQ requesters
// INTERFPGA_ARB_TAG_EN: precede each payload byte with tag {4'hA, grant_id}
module interfpga_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int SEND_TIMEOUT = 8,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    interfpga_tx_arbiter_if.master     bus,
    output logic                       active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       err_timeout
);
    localparam int W  = $clog2(NUM_REQ);
    localparam int CW = $clog2((SEND_TIMEOUT > GAP_CYCLES ? SEND_TIMEOUT : GAP_CYCLES) + 1);

`ifdef INTERFPGA_ARB_TAG_EN
    typedef enum logic [2:0] {IDLE, SEND, WAIT_DONE, GAP, TAG} state_t;
    localparam state_t FIRST = TAG;
`else
    typedef enum logic [2:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;
    localparam state_t FIRST = SEND;
`endif

    state_t               state, state_n, nxt;
    logic [CW-1:0]        cnt, cnt_n;
    logic [W-1:0]         last, winner;
    logic [NUM_REQ-1:0]   req_ack;
    logic [7:0]           tx_data;
    logic                 grab, err_n;

`ifdef INTERFPGA_ARB_TAG_EN
    logic                 pend;
    logic [7:0]           shadow;
    // pend: tag accepted, payload still owed after the gap
    assign nxt = pend ? SEND : IDLE;
`else
    assign nxt = IDLE;
`endif

    assign bus.req_ack = req_ack;
    assign bus.tx_data = tx_data;
    assign bus.tx_send = state == FIRST || state == SEND;
    assign active      = state != IDLE;

    // descending search so the nearest requester after last wins
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (bus.req_valid[W'((int'(last) + k) % NUM_REQ)]) winner = W'((int'(last) + k) % NUM_REQ);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = 1'b0;
        grab    = 1'b0;
        case (state)
            IDLE: begin
                grab    = |bus.req_valid;
                state_n = grab ? FIRST : IDLE;
                cnt_n   = '0;
            end
`ifdef INTERFPGA_ARB_TAG_EN
            TAG,
`endif
            SEND: begin
                if (bus.tx_busy) begin
                    state_n = WAIT_DONE;
                    cnt_n   = '0;
                end else if (int'(cnt) + 1 >= SEND_TIMEOUT) begin
                    state_n = GAP_CYCLES == 0 ? IDLE : GAP;
                    err_n   = 1'b1;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            WAIT_DONE: state_n = bus.tx_busy ? WAIT_DONE : (GAP_CYCLES == 0 ? nxt : GAP);
            GAP: begin
                if (int'(cnt) + 1 >= GAP_CYCLES) begin
                    state_n = nxt;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt         <= '0;
            req_ack     <= '0;
            err_timeout <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            last        <= W'(NUM_REQ - 1);
`ifdef INTERFPGA_ARB_TAG_EN
            pend        <= 1'b0;
            shadow      <= '0;
`endif
        end else begin
            cnt         <= cnt_n;
            req_ack     <= grab ? NUM_REQ'(1) << winner : '0;
            err_timeout <= err_n;
            if (grab) begin
                grant_id <= winner;
                last     <= winner;
`ifdef INTERFPGA_ARB_TAG_EN
                tx_data  <= {4'hA, 4'(winner)};
                shadow   <= bus.req_data[8*winner +: 8];
`else
                tx_data  <= bus.req_data[8*winner +: 8];
`endif
            end
`ifdef INTERFPGA_ARB_TAG_EN
            pend <= (state == TAG && bus.tx_busy) || (pend && state_n != SEND);
            if (pend && state_n == SEND) tx_data <= shadow;
`endif
        end
endmodule

// File: doc/interfpga_tx_arbiter.md
Name: interfpga_tx_arbiter

Overview:
Shares one interfpga_send link transmitter among NUM_REQ local requesters.
- Round-robin arbitration; latches the granted byte.
- Sequences the sender's send/busy handshake, with a timeout on a sender that never goes busy.
- Enforces a minimum idle gap between link bytes.
- Sits between on-chip producers and interfpga_send on the transmitting FPGA.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
SEND_TIMEOUT, 8, cycles tx_send may stay high without tx_busy before the byte is dropped
GAP_CYCLES, 1, idle cycles enforced after tx_busy falls before the next grant (0 allowed)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  NUM_REQ  per-requester byte pending; held until matching req_ack
req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i]
req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i latched
tx_data  out  8  to interfpga_send.data
tx_send  out  1  to interfpga_send.send
tx_busy  in  1  from interfpga_send.busy
active  out  1  high while a byte is owned by the arbiter (states ≠ IDLE)
grant_id  out  clog2(NUM_REQ)  requester currently/last served
err_timeout  out  1  one-cycle pulse when a byte is dropped on timeout

Behaviour:
- Reset (reset=0, async): state=IDLE, tx_data=0, tx_send=0, req_ack=0, active=0, grant_id=0, err_timeout=0, rr pointer last=NUM_REQ-1 (requester 0 wins first), counters=0.
- States: IDLE, SEND, WAIT_DONE, GAP (TAG when the feature is enabled).
- IDLE, any req_valid=1:
  - Winner is the first set bit searching last+1, last+2, … modulo NUM_REQ.
  - Same edge: tx_data<=req_data[winner], grant_id<=winner, last<=winner, req_ack[winner] pulses high for exactly that cycle, next state SEND.
  - Latency: req_valid seen → tx_send high = 1 cycle.
- SEND: tx_send=1.
  - Sampled tx_busy=1 → WAIT_DONE; tx_send low from the next cycle.
  - Otherwise the timeout counter increments. When it reaches SEND_TIMEOUT: tx_send drops, err_timeout pulses 1 cycle, byte is discarded (no retry, ack already given), next state GAP.
- WAIT_DONE: tx_send=0; stay until sampled tx_busy=0, then GAP.
- GAP: count GAP_CYCLES cycles, then IDLE. GAP_CYCLES=0 → GAP lasts 0 cycles (direct to IDLE).
- active=1 in SEND, WAIT_DONE, GAP, TAG.
- req_valid changes while not in IDLE are ignored; no new grant until back in IDLE.
- Requester dropping req_valid before its ack: never served, no ack.
- All requesters valid continuously: grants rotate 0,1,2,3,0… with no starvation.
- tx_busy already high on SEND entry: counts as accepted immediately.
- tx_busy rising while in IDLE/GAP: ignored.
- tx_data stays stable from latch until the next grant.
- Reset asserted mid-transfer: immediate return to reset values; the in-flight byte is abandoned and no ack is replayed.

Optional Feature:
Macro INTERFPGA_ARB_TAG_EN.
- Defined: each grant sends a tag byte {4'hA, 4'(grant_id)} first through a full SEND/WAIT_DONE/GAP cycle (TAG phase uses the same timeout), then the payload byte.
  - Payload held in a shadow register; ack still pulses at grant time.
  - Tag timeout drops both bytes with one err_timeout pulse.
- Undefined: no TAG state, no shadow register; only payload bytes are sent.

Test Plan:
1. Reset then reset=1, req_valid=4'b0001, req_data[7:0]=8'h12, sender model raises busy 1 cycle after send for 6 cycles → req_ack[0] pulses once, tx_data=8'h12, tx_send high exactly until busy seen, err_timeout never set.
2. req_valid=4'b1111 held, data 8'h34,8'h56,8'h78,8'h9A, re-asserted after each ack → grant_id sequence 0,1,2,3,0; tx_data matches the requester each time; ≥GAP_CYCLES idle between busy fall and next tx_send.
3. Sender model never asserts busy, req_valid=4'b0100 data 8'hBC → tx_send high exactly 8 cycles, err_timeout 1-cycle pulse, req_ack[2] pulsed at grant, state back to IDLE.
4. In WAIT_DONE, raise req_valid=4'b0010 and drop it before busy falls → no ack for requester 1, no extra tx_send.
5. Assert reset=0 mid-SEND with 8'hDE latched → tx_send, active, req_ack go 0 asynchronously; after release requester 0 wins first.
6. INTERFPGA_ARB_TAG_EN defined, requester 3 sends 8'h5A → link carries 8'hA3 then 8'h5A; single ack.
